free_list_ckpt_ctrl: RTL and testbench

Branch checkpoint controller for the R10K rename stage's physical-register free list. It holds up to `CKPT_DEPTH` age-ordered snapshots of the free list, one taken per dispatched branch. Each live snapshot tracks later retirements. On a mispredict it drives `free_list_restore`/`restore_flag` into FreddyList and reports which checkpoints are squashed. It sits between dispatch, branch resolution (execute) and FreddyList.

---
 rtl/free_list_ckpt_ctrl_pkg.sv | 34 +++
 rtl/free_list_ckpt_ctrl_retire_bitvec_decode.sv | 26 ++
 rtl/free_list_ckpt_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_free_list_ckpt_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_ckpt_ctrl_pkg.sv
// Shared rename-stage definitions for the free-list checkpoint controller.
//
// Contents:
//   N, NUM_SCALAR_BITS     - superscalar retire width and its count width
//   PHYS_REG_SZ_R10K       - number of physical registers (free-list width)
//   PHYS_REG_IDX           - physical register index type
//   CKPT_DEPTH, CKPT_ID_BITS, CKPT_ID - default checkpoint geometry
//   CKPT_ENTRY             - one checkpoint slot {valid, free_list}
//   ckpt_state_e           - controller FSM states
package free_list_ckpt_ctrl_pkg;

  localparam int unsigned N                 = 2;
  localparam int unsigned NUM_SCALAR_BITS   = $clog2(N + 1);
  localparam int unsigned PHYS_REG_SZ_R10K  = 64;
  localparam int unsigned PHYS_REG_IDX_BITS = $clog2(PHYS_REG_SZ_R10K);

  typedef logic [PHYS_REG_IDX_BITS-1:0] PHYS_REG_IDX;

  localparam int unsigned CKPT_DEPTH   = 4;
  localparam int unsigned CKPT_ID_BITS = $clog2(CKPT_DEPTH);

  typedef logic [CKPT_ID_BITS-1:0] CKPT_ID;

  typedef struct packed {
    logic                        valid;
    logic [PHYS_REG_SZ_R10K-1:0] free_list;
  } CKPT_ENTRY;

  typedef enum logic [0:0] {
    StIdle,
    StRestore
  } ckpt_state_e;

endpackage

// File: rtl/free_list_ckpt_ctrl_retire_bitvec_decode.sv
// Retire bit-vector decode (retire_bitvec_decode) for the checkpoint controller.
// Turns the T_old indices retiring this cycle into a one-hot OR vector over the
// physical register file. Only entries 0..num_retiring_valid-1 contribute.
//
// Ports:
//   phys_reg_retiring  in  [N] PHYS_REG_IDX  retiring T_old indices
//   num_retiring_valid in  NUM_SCALAR_BITS   count of valid leading entries
//   retire_vec         out PHYS_REG_SZ_R10K  OR of one-hot(index) over valid entries
module free_list_ckpt_ctrl_retire_bitvec_decode
  import free_list_ckpt_ctrl_pkg::*;
(
  input  PHYS_REG_IDX                 phys_reg_retiring [N],
  input  logic [NUM_SCALAR_BITS-1:0]  num_retiring_valid,
  output logic [PHYS_REG_SZ_R10K-1:0] retire_vec
);

  always_comb begin
    retire_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (NUM_SCALAR_BITS'(i) < num_retiring_valid) begin
        retire_vec[phys_reg_retiring[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/free_list_ckpt_ctrl.sv
// Branch checkpoint controller for the R10K rename-stage free list.
//
// Holds up to CKPT_DEPTH age-ordered free-list snapshots in a circular buffer
// (head = oldest, tail = next to allocate). Every live snapshot keeps ORing in
// registers freed by retirement so that a restore hands FreddyList a list that
// already includes everything retired since the branch dispatched. A mispredict
// drives a one-cycle restore pulse with the snapshot and the set of squashed
// slots (the mispredicted slot and everything younger).
//
// Ports:
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   ckpt_req              dispatch has a branch this cycle
//   ckpt_free_list        free list just after the branch's own allocation
//   ckpt_grant / ckpt_id  combinational accept and the slot given to the branch
//   ckpt_mask             live-checkpoint vector (state after the previous edge)
//   full                  no slot free (state after the previous edge)
//   phys_reg_retiring     retiring T_old indices, num_retiring_valid of them valid
//   resolve_valid/_id/_mispredict  branch resolution from execute
//   free_list_restore     registered snapshot for FreddyList
//   restore_flag          registered one-cycle restore pulse
//   squash_mask           registered slots killed by the restore
//   ckpt_count            occupancy, only with FREE_LIST_CKPT_DEBUG_EN
//
// Build option: define FREE_LIST_CKPT_DEBUG_EN to add the ckpt_count port and a
// check that a grant is never issued while full.
module free_list_ckpt_ctrl
  import free_list_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned CKPT_DEPTH   = free_list_ckpt_ctrl_pkg::CKPT_DEPTH,
  parameter int unsigned CKPT_ID_BITS = $clog2(CKPT_DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ckpt_req,
  input  logic [PHYS_REG_SZ_R10K-1:0] ckpt_free_list,
  output logic                        ckpt_grant,
  output logic [CKPT_ID_BITS-1:0]     ckpt_id,
  output logic [CKPT_DEPTH-1:0]       ckpt_mask,
  output logic                        full,
  input  PHYS_REG_IDX                 phys_reg_retiring [N],
  input  logic [NUM_SCALAR_BITS-1:0]  num_retiring_valid,
  input  logic                        resolve_valid,
  input  logic [CKPT_ID_BITS-1:0]     resolve_id,
  input  logic                        resolve_mispredict,
  output logic [PHYS_REG_SZ_R10K-1:0] free_list_restore,
  output logic                        restore_flag,
  output logic [CKPT_DEPTH-1:0]       squash_mask
`ifdef FREE_LIST_CKPT_DEBUG_EN
  ,
  output logic [CKPT_ID_BITS:0]       ckpt_count
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [CKPT_ID_BITS:0] ptr_t;

  ckpt_state_e state_q;
  CKPT_ENTRY   entry_q [CKPT_DEPTH];
  ptr_t        head_q;
  ptr_t        tail_q;

  logic [PHYS_REG_SZ_R10K-1:0] retire_vec;

  ptr_t                    occupancy;
  logic [CKPT_DEPTH-1:0]   valid_vec;
  logic [CKPT_DEPTH-1:0]   squash_vec;
  logic [CKPT_ID_BITS-1:0] head_idx;
  logic [CKPT_ID_BITS-1:0] tail_idx;
  logic [CKPT_ID_BITS-1:0] k_off;
  logic [CKPT_ID_BITS-1:0] slot_off;
  logic                    resolve_hit;
  logic                    mispredict_req;
  logic                    mispredict_accept;
  logic                    correct_accept;
  logic                    head_advance;

  free_list_ckpt_ctrl_retire_bitvec_decode u_retire_decode (
    .phys_reg_retiring  (phys_reg_retiring),
    .num_retiring_valid (num_retiring_valid),
    .retire_vec         (retire_vec)
  );

  always_comb begin
    head_idx  = head_q[CKPT_ID_BITS-1:0];
    tail_idx  = tail_q[CKPT_ID_BITS-1:0];
    occupancy = tail_q - head_q;

    valid_vec = '0;
    for (int unsigned i = 0; i < CKPT_DEPTH; i++) begin
      valid_vec[i] = entry_q[i].valid;
    end

    resolve_hit       = resolve_valid & valid_vec[resolve_id];
    mispredict_req    = resolve_hit & resolve_mispredict;
    mispredict_accept = mispredict_req & (state_q == StIdle);
    correct_accept    = resolve_hit & ~resolve_mispredict & (state_q == StIdle);

    // Holes left by out-of-order resolves are reclaimed one per cycle.
    head_advance = (head_q != tail_q) & ~valid_vec[head_idx];

    // Age position of the mispredicted slot; everything at or past it up to the
    // tail is younger and gets squashed.
    k_off      = resolve_id - head_idx;
    slot_off   = '0;
    squash_vec = '0;
    for (int unsigned i = 0; i < CKPT_DEPTH; i++) begin
      slot_off      = CKPT_ID_BITS'(i) - head_idx;
      squash_vec[i] = ({1'b0, slot_off} >= {1'b0, k_off}) && ({1'b0, slot_off} < occupancy);
    end
  end

  assign full       = (occupancy == ptr_t'(CKPT_DEPTH));
  assign ckpt_mask  = valid_vec;
  assign ckpt_grant = ckpt_req & ~full & (state_q == StIdle) & ~mispredict_req;
  assign ckpt_id    = tail_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= StIdle;
      head_q            <= '0;
      tail_q            <= '0;
      restore_flag      <= 1'b0;
      free_list_restore <= '0;
      squash_mask       <= '0;
      for (int unsigned i = 0; i < CKPT_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      restore_flag <= 1'b0;

      for (int unsigned i = 0; i < CKPT_DEPTH; i++) begin
        if (entry_q[i].valid) begin
          entry_q[i].free_list <= entry_q[i].free_list | retire_vec;
        end
      end

      if (head_advance) begin
        head_q <= head_q + ptr_t'(1);
      end

      // The tail slot is never valid when a grant is possible, so this does
      // not collide with the retire merge above.
      if (ckpt_grant) begin
        entry_q[tail_idx] <= '{valid: 1'b1, free_list: ckpt_free_list | retire_vec};
        tail_q            <= tail_q + ptr_t'(1);
      end

      if (correct_accept) begin
        entry_q[resolve_id].valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (mispredict_accept) begin
            state_q           <= StRestore;
            restore_flag      <= 1'b1;
            free_list_restore <= entry_q[resolve_id].free_list | retire_vec;
            squash_mask       <= squash_vec;
            tail_q            <= head_q + {1'b0, k_off};
            for (int unsigned i = 0; i < CKPT_DEPTH; i++) begin
              if (squash_vec[i]) begin
                entry_q[i].valid <= 1'b0;
              end
            end
          end
        end
        StRestore: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef FREE_LIST_CKPT_DEBUG_EN
  assign ckpt_count = occupancy;

  grant_never_full_a: assert property (@(posedge clock) disable iff (reset)
    !(ckpt_grant && full));
`endif

endmodule

// File: tb/tb_free_list_ckpt_ctrl.sv
// Self-checking bench for free_list_ckpt_ctrl (CKPT_DEPTH = 4).
// Restore pulses are checked against a scoreboard of expected
// {free_list_restore, squash_mask} pushed when each mispredict is driven.
module tb_free_list_ckpt_ctrl;
  import free_list_ckpt_ctrl_pkg::*;

  typedef struct packed {
    logic [PHYS_REG_SZ_R10K-1:0] flr;
    logic [3:0]                  squash;
  } exp_t;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        ckpt_req;
  logic [PHYS_REG_SZ_R10K-1:0] ckpt_free_list;
  logic                        ckpt_grant;
  logic [1:0]                  ckpt_id;
  logic [3:0]                  ckpt_mask;
  logic                        full;
  PHYS_REG_IDX                 phys_reg_retiring [N];
  logic [NUM_SCALAR_BITS-1:0]  num_retiring_valid;
  logic                        resolve_valid;
  logic [1:0]                  resolve_id;
  logic                        resolve_mispredict;
  logic [PHYS_REG_SZ_R10K-1:0] free_list_restore;
  logic                        restore_flag;
  logic [3:0]                  squash_mask;
`ifdef FREE_LIST_CKPT_DEBUG_EN
  logic [2:0]                  ckpt_count;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clock = ~clock;

  free_list_ckpt_ctrl #(
    .CKPT_DEPTH   (4),
    .CKPT_ID_BITS (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .ckpt_req           (ckpt_req),
    .ckpt_free_list     (ckpt_free_list),
    .ckpt_grant         (ckpt_grant),
    .ckpt_id            (ckpt_id),
    .ckpt_mask          (ckpt_mask),
    .full               (full),
    .phys_reg_retiring  (phys_reg_retiring),
    .num_retiring_valid (num_retiring_valid),
    .resolve_valid      (resolve_valid),
    .resolve_id         (resolve_id),
    .resolve_mispredict (resolve_mispredict),
    .free_list_restore  (free_list_restore),
    .restore_flag       (restore_flag),
    .squash_mask        (squash_mask)
`ifdef FREE_LIST_CKPT_DEBUG_EN
    ,
    .ckpt_count         (ckpt_count)
`endif
  );

  // Scoreboard consumer: every restore pulse must match a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (restore_flag === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_restore: restore_flag=1 with no mispredict pending");
        end else begin
          e = sb.pop_front();
          checks++;
          if (free_list_restore !== e.flr) begin
            errors++;
            $display("FAIL sb_free_list_restore: got %h expected %h", free_list_restore, e.flr);
          end
          checks++;
          if (squash_mask !== e.squash) begin
            errors++;
            $display("FAIL sb_squash_mask: got %b expected %b", squash_mask, e.squash);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ckpt_req             = 1'b0;
    ckpt_free_list       = '0;
    phys_reg_retiring[0] = '0;
    phys_reg_retiring[1] = '0;
    num_retiring_valid   = '0;
    resolve_valid        = 1'b0;
    resolve_id           = '0;
    resolve_mispredict   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [PHYS_REG_SZ_R10K-1:0] fl, input logic [1:0] exp_id);
    ckpt_req       = 1'b1;
    ckpt_free_list = fl;
    #1;
    checks++;
    if (ckpt_grant !== 1'b1) begin
      errors++; $display("FAIL alloc_grant: got %b expected 1", ckpt_grant);
    end
    checks++;
    if (ckpt_id !== exp_id) begin
      errors++; $display("FAIL alloc_id: got %0d expected %0d", ckpt_id, exp_id);
    end
    cyc();
    ckpt_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    checks++;
    if (ckpt_mask !== 4'b0000) begin
      errors++; $display("FAIL reset_mask: got %b expected 0000", ckpt_mask);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++; $display("FAIL reset_full: got %b expected 0", full);
    end
    checks++;
    if (restore_flag !== 1'b0) begin
      errors++; $display("FAIL reset_restore_flag: got %b expected 0", restore_flag);
    end
    checks++;
    if (free_list_restore !== '0) begin
      errors++; $display("FAIL reset_flr: got %h expected 0", free_list_restore);
    end
    checks++;
    if (squash_mask !== 4'b0000) begin
      errors++; $display("FAIL reset_squash: got %b expected 0000", squash_mask);
    end
    reset = 1'b0;
  endtask

  // Five back-to-back requests: four grants, then full blocks the fifth.
  task automatic test_fill();
    for (int c = 0; c < 5; c++) begin
      ckpt_req       = 1'b1;
      ckpt_free_list = PHYS_REG_SZ_R10K'(c + 1);
      #1;
      checks++;
      if (ckpt_grant !== (c < 4)) begin
        errors++; $display("FAIL fill_grant[%0d]: got %b expected %b", c, ckpt_grant, c < 4);
      end
      if (c < 4) begin
        checks++;
        if (ckpt_id !== 2'(c)) begin
          errors++; $display("FAIL fill_id[%0d]: got %0d expected %0d", c, ckpt_id, c);
        end
      end
      checks++;
      if (full !== (c == 4)) begin
        errors++; $display("FAIL fill_full[%0d]: got %b expected %b", c, full, c == 4);
      end
      cyc();
    end
    ckpt_req = 1'b0;
    checks++;
    if (ckpt_mask !== 4'b1111) begin
      errors++; $display("FAIL fill_mask: got %b expected 1111", ckpt_mask);
    end
  endtask

  // Out-of-order correct resolves leave a hole that head cannot skip.
  task automatic test_resolve_holes();
    resolve_valid = 1'b1; resolve_id = 2'd2; resolve_mispredict = 1'b0;
    cyc();
    resolve_valid = 1'b0;
    checks++;
    if (ckpt_mask !== 4'b1011) begin
      errors++; $display("FAIL hole_mask: got %b expected 1011", ckpt_mask);
    end
    cyc();
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL hole_still_full: got %b expected 1", full);
    end
    resolve_valid = 1'b1; resolve_id = 2'd0;
    cyc();
    resolve_valid = 1'b0;
    checks++;
    if (full !== 1'b1 || ckpt_mask !== 4'b1010) begin
      errors++; $display("FAIL head_resolve: got full=%b mask=%b expected full=1 mask=1010",
                         full, ckpt_mask);
    end
    cyc();
    checks++;
    if (full !== 1'b0) begin
      errors++; $display("FAIL head_advanced_full: got %b expected 0", full);
    end
    // Slot 0 is reusable once head has moved past it; slot 2 stays a hole.
    alloc(64'h55, 2'd0);
    checks++;
    if (full !== 1'b1 || ckpt_mask !== 4'b1011) begin
      errors++; $display("FAIL wrap_alloc: got full=%b mask=%b expected full=1 mask=1011",
                         full, ckpt_mask);
    end
  endtask

  // Retirements after a snapshot land in the restored list; inactive retire
  // lanes must not.
  task automatic test_restore_retire();
    logic [PHYS_REG_SZ_R10K-1:0] l0;
    logic [PHYS_REG_SZ_R10K-1:0] b7;
    logic [PHYS_REG_SZ_R10K-1:0] b9;
    l0 = 64'hF000_0000_0000_00F0;
    b7 = 64'd1 << 7;
    b9 = 64'd1 << 9;
    do_reset();
    alloc(l0, 2'd0);
    alloc(64'h0, 2'd1);
    alloc(64'h1, 2'd2);
    alloc(64'h2, 2'd3);
    phys_reg_retiring[0] = 6'd7; num_retiring_valid = 2'd1;
    cyc();
    phys_reg_retiring[0] = 6'd9; phys_reg_retiring[1] = 6'd20; num_retiring_valid = 2'd1;
    cyc();
    num_retiring_valid = 2'd0;
    resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
    sb.push_back('{flr: b7 | b9, squash: 4'b1110});
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    checks++;
    if (restore_flag !== 1'b1) begin
      errors++; $display("FAIL mp1_restore_flag: got %b expected 1", restore_flag);
    end
    checks++;
    if (ckpt_mask !== 4'b0001 || full !== 1'b0) begin
      errors++; $display("FAIL mp1_mask: got mask=%b full=%b expected mask=0001 full=0",
                         ckpt_mask, full);
    end
    cyc();
    checks++;
    if (restore_flag !== 1'b0) begin
      errors++; $display("FAIL mp1_pulse_width: got %b expected 0", restore_flag);
    end
    alloc(64'h100, 2'd1);
    // Slot 0 was live through both retirements.
    resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
    sb.push_back('{flr: l0 | b7 | b9, squash: 4'b0011});
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    cyc();
  endtask

  // A request colliding with a mispredict is refused, including in RESTORE.
  task automatic test_mispredict_with_req();
    logic [PHYS_REG_SZ_R10K-1:0] x;
    x = 64'hDEAD_0000_0000_BEE0;
    do_reset();
    phys_reg_retiring[0] = 6'd3; phys_reg_retiring[1] = 6'd5; num_retiring_valid = 2'd2;
    alloc(x, 2'd0);
    num_retiring_valid = 2'd0;
    alloc(64'h7, 2'd1);
    ckpt_req = 1'b1; ckpt_free_list = 64'hFFFF;
    resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
    phys_reg_retiring[0] = 6'd11; num_retiring_valid = 2'd1;
    sb.push_back('{flr: x | (64'd1 << 3) | (64'd1 << 5) | (64'd1 << 11), squash: 4'b0011});
    #1;
    checks++;
    if (ckpt_grant !== 1'b0) begin
      errors++; $display("FAIL mp_req_grant: got %b expected 0", ckpt_grant);
    end
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0; num_retiring_valid = 2'd0;
    #1;
    checks++;
    if (ckpt_grant !== 1'b0) begin
      errors++; $display("FAIL restore_state_grant: got %b expected 0", ckpt_grant);
    end
    cyc();
    checks++;
    if (ckpt_mask !== 4'b0000 || restore_flag !== 1'b0) begin
      errors++; $display("FAIL post_restore: got mask=%b flag=%b expected mask=0000 flag=0",
                         ckpt_mask, restore_flag);
    end
    ckpt_req = 1'b0;
    alloc(64'h9, 2'd0);
  endtask

  task automatic test_double_mispredict();
    do_reset();
    alloc(64'hA, 2'd0);
    alloc(64'hB, 2'd1);
    alloc(64'hC, 2'd2);
    resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
    sb.push_back('{flr: 64'hB, squash: 4'b0110});
    cyc();
    resolve_id = 2'd0;
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    checks++;
    if (restore_flag !== 1'b0) begin
      errors++; $display("FAIL double_mp_flag: got %b expected 0", restore_flag);
    end
    checks++;
    if (ckpt_mask !== 4'b0001) begin
      errors++; $display("FAIL double_mp_mask: got %b expected 0001", ckpt_mask);
    end
  endtask

  task automatic test_reset_in_restore();
    do_reset();
    alloc(64'h1234, 2'd0);
    alloc(64'h5678, 2'd1);
    resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
    sb.push_back('{flr: 64'h1234, squash: 4'b0011});
    cyc();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (restore_flag !== 1'b0 || free_list_restore !== '0 || squash_mask !== 4'b0000 ||
        ckpt_mask !== 4'b0000 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_restore: got flag=%b flr=%h squash=%b mask=%b full=%b expected all 0",
               restore_flag, free_list_restore, squash_mask, ckpt_mask, full);
    end
    alloc(64'h1, 2'd0);
  endtask

  // Allocate and correct-resolve in the same cycle, wrapping the ring.
  task automatic test_back_to_back();
    do_reset();
    alloc(64'h10, 2'd0);
    for (int i = 1; i < 7; i++) begin
      ckpt_req = 1'b1; ckpt_free_list = PHYS_REG_SZ_R10K'(i);
      resolve_valid = 1'b1; resolve_id = 2'(i - 1); resolve_mispredict = 1'b0;
      #1;
      checks++;
      if (ckpt_grant !== 1'b1 || ckpt_id !== 2'(i)) begin
        errors++; $display("FAIL b2b_grant[%0d]: got grant=%b id=%0d expected grant=1 id=%0d",
                           i, ckpt_grant, ckpt_id, i % 4);
      end
      cyc();
      checks++;
      if (ckpt_mask !== (4'b0001 << (i % 4))) begin
        errors++; $display("FAIL b2b_mask[%0d]: got %b expected %b", i, ckpt_mask,
                           4'b0001 << (i % 4));
      end
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_resolve_holes();
    test_restore_retire();
    test_mispredict_with_req();
    test_double_mispredict();
    test_reset_in_restore();
    test_back_to_back();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_missing_restore: %0d expected restores not seen", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
